// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_pkg
// Description : Shared types and constants for the Sobel window datapath:
//               pixel width, pixel/window types, 3x3 window index names and
//               default image dimensions.
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [0:8]     window_t;

    // Window positions: T/M/B = top/middle/bottom row, L/C/R = column.
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

endpackage : sobel_pkg
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sobel_line_buffer
// Description : One image line of pixel storage. Single write port and an
//               asynchronous read port sharing the same address; a read in
//               the write cycle returns the old (pre-write) contents.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_addr   - column address (read and write)
//               i_wdata  - pixel to store
//               o_rdata  - pixel currently stored at i_addr
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH
) (
    input  logic                         clk,
    input  logic                         i_we,
    input  logic [$clog2(IMG_WIDTH)-1:0] i_addr,
    input  pixel_t                       i_wdata,
    output pixel_t                       o_rdata
);

    // Contents are deliberately not reset: the row gating in the window
    // former guarantees every entry is rewritten before it is used.
    pixel_t r_mem [IMG_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule : sobel_line_buffer
`default_nettype wire

// File: rtl/sobel_window_generator.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_generator
// Description : Streaming 3x3 window former for the Sobel gradient stages.
//               Buffers the two previous lines of a raster pixel stream and
//               emits a 3x3 window with a one-cycle start_calculations strobe
//               for every fully-populated (unpadded) window position.
// Ports       : clk                - clock
//               reset              - asynchronous active-high reset
//               pixel_in           - raster pixel
//               pixel_valid        - pixel_in accepted this cycle
//               frame_start        - accepted pixel is (row 0, col 0)
//               windowBuffer       - 3x3 window, [0..2] oldest line
//               start_calculations - windowBuffer valid strobe
//               frame_done         - strobe after the last pixel of a frame
//               center_x/center_y  - window centre (SOBEL_WIN_COORD_EN only)
// Options     : SOBEL_WIN_COORD_EN - adds the centre coordinate outputs
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_generator
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  pixel_t                        pixel_in,
    input  logic                          pixel_valid,
    input  logic                          frame_start,
    output window_t                       windowBuffer,
    output logic                          start_calculations,
`ifdef SOBEL_WIN_COORD_EN
    output logic [$clog2(IMG_WIDTH)-1:0]  center_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] center_y,
`endif
    output logic                          frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] c_last_col = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] c_last_row = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] c_two_col  = CW'(2);
    localparam logic [RW-1:0] c_two_row  = RW'(2);
    localparam logic [CW-1:0] c_one_col  = CW'(1);
    localparam logic [RW-1:0] c_one_row  = RW'(1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    window_t       r_window;
    logic          r_start;
    logic          r_done;

    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;
    logic          w_last;
    logic          w_win_ok;
    pixel_t        w_line1_rd;
    pixel_t        w_line2_rd;

    // Effective position of the pixel being accepted; frame_start overrides
    // the running counters so a mid-frame restart is treated as (0,0).
    always_comb begin
        w_col     = frame_start ? '0 : r_col;
        w_row     = frame_start ? '0 : r_row;
        w_last    = (w_row == c_last_row) && (w_col == c_last_col);
        w_win_ok  = (w_row >= c_two_row) && (w_col >= c_two_col);
        w_col_nxt = w_col + c_one_col;
        w_row_nxt = w_row;
        if (w_col == c_last_col) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == c_last_row) ? '0 : (w_row + c_one_row);
        end
    end

    // line1 holds row r-1; its old contents cascade into line2 (row r-2).
    sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_line1 (
        .clk     (clk),
        .i_we    (pixel_valid),
        .i_addr  (w_col),
        .i_wdata (pixel_in),
        .o_rdata (w_line1_rd)
    );

    sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_line2 (
        .clk     (clk),
        .i_we    (pixel_valid),
        .i_addr  (w_col),
        .i_wdata (w_line1_rd),
        .o_rdata (w_line2_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col    <= '0;
            r_row    <= '0;
            r_window <= '0;
            r_start  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            if (pixel_valid) begin
                r_window[WIN_TL] <= r_window[WIN_TC];
                r_window[WIN_TC] <= r_window[WIN_TR];
                r_window[WIN_TR] <= w_line2_rd;
                r_window[WIN_ML] <= r_window[WIN_MC];
                r_window[WIN_MC] <= r_window[WIN_MR];
                r_window[WIN_MR] <= w_line1_rd;
                r_window[WIN_BL] <= r_window[WIN_BC];
                r_window[WIN_BC] <= r_window[WIN_BR];
                r_window[WIN_BR] <= pixel_in;
                r_start          <= w_win_ok;
                r_done           <= w_last;
                r_col            <= w_col_nxt;
                r_row            <= w_row_nxt;
            end
        end
    end

`ifdef SOBEL_WIN_COORD_EN
    logic [CW-1:0] r_center_x;
    logic [RW-1:0] r_center_y;

    // The window is centred one column and one row behind the new pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_center_x <= '0;
            r_center_y <= '0;
        end else if (pixel_valid && w_win_ok) begin
            r_center_x <= w_col - c_one_col;
            r_center_y <= w_row - c_one_row;
        end
    end

    assign center_x = r_center_x;
    assign center_y = r_center_y;
`endif

    assign windowBuffer       = r_window;
    assign start_calculations = r_start;
    assign frame_done         = r_done;

endmodule : sobel_window_generator
`default_nettype wire

// File: tb/tb_sobel_window_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_window_generator
// Description : Self-checking bench for sobel_window_generator. A 4x4
//               instance runs a vector table plus stall, reset and restart
//               sequences; a 5x3 instance runs back-to-back frames and a
//               frame_start on the last pixel position.
// Options     : SOBEL_WIN_COORD_EN - also checks centre coordinates
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_generator;
    import sobel_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic    reset;
    logic    a_valid, a_fs, a_start, a_done;
    pixel_t  a_pix;
    window_t a_win;
    logic    b_valid, b_fs, b_start, b_done;
    pixel_t  b_pix;
    window_t b_win;
`ifdef SOBEL_WIN_COORD_EN
    logic [1:0] a_cx, a_cy;
    logic [2:0] b_cx;
    logic [1:0] b_cy;
`endif

    sobel_window_generator #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk                (clk),
        .reset              (reset),
        .pixel_in           (a_pix),
        .pixel_valid        (a_valid),
        .frame_start        (a_fs),
        .windowBuffer       (a_win),
        .start_calculations (a_start),
`ifdef SOBEL_WIN_COORD_EN
        .center_x           (a_cx),
        .center_y           (a_cy),
`endif
        .frame_done         (a_done)
    );

    sobel_window_generator #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
        .clk                (clk),
        .reset              (reset),
        .pixel_in           (b_pix),
        .pixel_valid        (b_valid),
        .frame_start        (b_fs),
        .windowBuffer       (b_win),
        .start_calculations (b_start),
`ifdef SOBEL_WIN_COORD_EN
        .center_x           (b_cx),
        .center_y           (b_cy),
`endif
        .frame_done         (b_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int a_strb  = 0;
    int b_strb  = 0;
    int b_dn    = 0;

    always @(negedge clk) begin
        if (a_start) a_strb++;
        if (b_start) b_strb++;
        if (b_done)  b_dn++;
    end

    typedef struct {
        logic    valid;
        logic    fs;
        pixel_t  pix;
        logic    exp_start;
        logic    exp_done;
        window_t exp_win;
        logic [1:0] exp_cx;
        logic [1:0] exp_cy;
    } vec_t;

    vec_t    tbl [16];
    window_t w_first, w_second;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input window_t act, input window_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle on instance A and sample #1 after the edge.
    task automatic a_cycle(input logic v, input logic fs, input pixel_t p);
        a_valid = v;
        a_fs    = fs;
        a_pix   = p;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_fs    = 1'b0;
    endtask

    task automatic b_cycle(input logic v, input logic fs, input pixel_t p);
        b_valid = v;
        b_fs    = fs;
        b_pix   = p;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        b_fs    = 1'b0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 16; i++) begin
            a_cycle(tbl[i].valid, tbl[i].fs, tbl[i].pix);
            chk($sformatf("%s start[%0d]", tag, i), 32'(a_start), 32'(tbl[i].exp_start));
            chk($sformatf("%s done[%0d]", tag, i), 32'(a_done), 32'(tbl[i].exp_done));
            if (tbl[i].exp_start) begin
                chkw($sformatf("%s window[%0d]", tag, i), a_win, tbl[i].exp_win);
`ifdef SOBEL_WIN_COORD_EN
                chk($sformatf("%s cx[%0d]", tag, i), 32'(a_cx), 32'(tbl[i].exp_cx));
                chk($sformatf("%s cy[%0d]", tag, i), 32'(a_cy), 32'(tbl[i].exp_cy));
`endif
            end
        end
        @(negedge clk);
        #1;
        chk({tag, " strobe count"}, 32'(a_strb), 32'd4);
    endtask

    initial begin
        // 4x4 frame, pixel = 16r + c; strobes at (2,2),(2,3),(3,2),(3,3).
        for (int i = 0; i < 16; i++) begin
            tbl[i].valid     = 1'b1;
            tbl[i].fs        = (i == 0);
            tbl[i].pix       = pixel_t'(16 * (i / 4) + (i % 4));
            tbl[i].exp_start = 1'b0;
            tbl[i].exp_done  = 1'b0;
            tbl[i].exp_win   = '0;
            tbl[i].exp_cx    = 2'd0;
            tbl[i].exp_cy    = 2'd0;
        end
        tbl[10].exp_start = 1'b1;
        tbl[10].exp_win   = {8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34};
        tbl[10].exp_cx    = 2'd1; tbl[10].exp_cy = 2'd1;
        tbl[11].exp_start = 1'b1;
        tbl[11].exp_win   = {8'd1, 8'd2, 8'd3, 8'd17, 8'd18, 8'd19, 8'd33, 8'd34, 8'd35};
        tbl[11].exp_cx    = 2'd2; tbl[11].exp_cy = 2'd1;
        tbl[14].exp_start = 1'b1;
        tbl[14].exp_win   = {8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34, 8'd48, 8'd49, 8'd50};
        tbl[14].exp_cx    = 2'd1; tbl[14].exp_cy = 2'd2;
        tbl[15].exp_start = 1'b1;
        tbl[15].exp_done  = 1'b1;
        tbl[15].exp_win   = {8'd17, 8'd18, 8'd19, 8'd33, 8'd34, 8'd35, 8'd49, 8'd50, 8'd51};
        tbl[15].exp_cx    = 2'd2; tbl[15].exp_cy = 2'd2;
        w_first  = tbl[10].exp_win;
        w_second = tbl[11].exp_win;

        reset = 1'b1;
        a_valid = 1'b0; a_fs = 1'b0; a_pix = '0;
        b_valid = 1'b0; b_fs = 1'b0; b_pix = '0;
        repeat (2) @(posedge clk);
        #1;
        chkw("reset window", a_win, '0);
        chk("reset start", 32'(a_start), 32'd0);
        chk("reset done", 32'(a_done), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Continuous 4x4 frame.
        a_strb = 0;
        run_table("t1");

        // Stall for 3 cycles after pixel (2,2): window held, no strobe.
        a_strb = 0;
        for (int i = 0; i < 16; i++) begin
            a_cycle(1'b1, (i == 0), tbl[i].pix);
            if (i == 10) begin
                chkw("stall first window", a_win, w_first);
                for (int k = 0; k < 3; k++) begin
                    a_cycle(1'b0, 1'b0, 8'hEE);
                    chkw($sformatf("stall hold[%0d]", k), a_win, w_first);
                    chk($sformatf("stall start[%0d]", k), 32'(a_start), 32'd0);
                    chk($sformatf("stall done[%0d]", k), 32'(a_done), 32'd0);
                end
            end
            if (i == 11) begin
                chkw("stall next window", a_win, w_second);
                chk("stall next start", 32'(a_start), 32'd1);
            end
        end
        @(negedge clk);
        #1;
        chk("stall strobe count", 32'(a_strb), 32'd4);

        // Asynchronous reset after pixel (3,1), then full replay.
        for (int i = 0; i < 14; i++) a_cycle(1'b1, (i == 0), tbl[i].pix);
        #2;
        reset = 1'b1;
        #1;
        chkw("async reset window", a_win, '0);
        chk("async reset start", 32'(a_start), 32'd0);
        chk("async reset done", 32'(a_done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_strb = 0;
        run_table("replay");

        // frame_start at old pixel (2,1): new frame values 128 + 16r + c.
        for (int i = 0; i < 9; i++) a_cycle(1'b1, (i == 0), tbl[i].pix);
        a_strb = 0;
        for (int i = 0; i < 16; i++) begin
            a_cycle(1'b1, (i == 0), pixel_t'(128 + 16 * (i / 4) + (i % 4)));
            chk($sformatf("restart start[%0d]", i), 32'(a_start),
                32'((i == 10) || (i == 11) || (i == 14) || (i == 15)));
            if (i == 10)
                chkw("restart first window", a_win,
                     {8'd128, 8'd129, 8'd130, 8'd144, 8'd145, 8'd146, 8'd160, 8'd161, 8'd162});
        end
        @(negedge clk);
        #1;
        chk("restart strobe count", 32'(a_strb), 32'd4);

        // 5x3 back-to-back frames.
        b_strb = 0;
        b_dn   = 0;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 15; i++)
                b_cycle(1'b1, (i == 0), pixel_t'(7 * i + f));
        @(negedge clk);
        #1;
        chk("b2b strobe count", 32'(b_strb), 32'd9);
        chk("b2b done count", 32'(b_dn), 32'd3);

        // frame_start on the last-pixel position wins over frame_done.
        for (int i = 0; i < 14; i++) b_cycle(1'b1, (i == 0), pixel_t'(i));
        b_cycle(1'b1, 1'b1, 8'h55);
        chk("fs@last start", 32'(b_start), 32'd0);
        chk("fs@last done", 32'(b_done), 32'd0);
        @(negedge clk);
        #1;
        chk("fs@last strobe count", 32'(b_strb), 32'd11);
        chk("fs@last done count", 32'(b_dn), 32'd3);
        for (int i = 1; i < 15; i++) b_cycle(1'b1, 1'b0, pixel_t'(i));
        chk("fs@last final done", 32'(b_done), 32'd1);
        @(negedge clk);
        #1;
        chk("fs@last end strobes", 32'(b_strb), 32'd14);
        chk("fs@last end done count", 32'(b_dn), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sobel_window_generator
`default_nettype wire

// File: doc/sobel_window_generator.md
# sobel_window_generator

Streaming 3x3 window former that feeds the Sobel gradient stages. It accepts a raster-scan 8-bit pixel stream one pixel per valid cycle and buffers the two previous image lines. It presents a 9-pixel window `windowBuffer[0:8]` plus a one-cycle `start_calculations` strobe, which `vertical_gradient` and the horizontal-gradient block consume directly. It is the producer end of that window interface.

## Interface
- `IMG_WIDTH`, default 640: pixels per line, must be ≥ 3.
- `IMG_HEIGHT`, default 480: lines per frame, must be ≥ 3.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `pixel_in` input, 8 bits: raster pixel, unsigned.
- `pixel_valid` input, 1 bit: `pixel_in` accepted this cycle. There is no backpressure.
- `frame_start` input, 1 bit: qualified by `pixel_valid`; marks that pixel as (row 0, col 0).
- `windowBuffer` output, 8 bits × [0:8]: the 3x3 window. P0..P2 is the top row (oldest line), P6..P8 is the bottom row (current line). Within each row, left to right is the oldest column to the current column.
- `start_calculations` output, 1 bit: one-cycle strobe; `windowBuffer` is valid this cycle.
- `frame_done` output, 1 bit: one-cycle strobe after the last pixel (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.

## Operation
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) give the position of the next pixel.
- Accepting a pixel at (r,c) does all of the following in the same edge:
  - Read `a = line1[c]` and `b = line2[c]`, where line1 holds row r-1 and line2 holds row r-2.
  - Write `line2[c] <= a` and `line1[c] <= pixel_in`. Reads return the pre-write (old) data.
  - Shift the window one column left: P0←P1←P2, P3←P4←P5, P6←P7←P8.
  - Load the new right column: P2←b, P5←a, P8←pixel_in.
  - Advance `col`. At IMG_WIDTH-1 it wraps to 0 and `row` increments. At the last pixel both counters return to 0.
- `start_calculations` is registered high for the pixel accepted at (r,c) only when r ≥ 2 and c ≥ 2. The window is then centred at (r-1,c-1).
- No border padding. Each frame yields exactly (IMG_WIDTH-2)(IMG_HEIGHT-2) strobes. Stale columns left over from the previous line at c = 0,1 are never flagged.
- `frame_start` with `pixel_valid`: the pixel is treated as (0,0) and the counters are forced accordingly, even mid-frame. Windows resume only after two new lines plus 3 pixels have been received.
- `pixel_valid` low: all state holds; `start_calculations` and `frame_done` are low.
- Arithmetic: none on pixel data. The counters are ceil(log2) of the dimension wide, with an explicit compare for wrap (no power-of-two assumption).

## Timing
- Latency: `start_calculations` and the new `windowBuffer` appear 1 cycle after the accepting edge.
- Throughput is 1 window per cycle under continuous `pixel_valid`.
- `windowBuffer` holds its value between strobes.
- `frame_done` is asserted in the same cycle as the final `start_calculations` strobe of the frame.
- Reset (asynchronous, any time, including mid-frame):
  - `windowBuffer` = all 0; `start_calculations` = 0; `frame_done` = 0; `row` = 0; `col` = 0.
  - Line buffer contents are not reset and their value is don't-care. The row ≥ 2 gating guarantees they are rewritten before use.
- Simultaneous `frame_start` on the last-pixel position: `frame_start` wins. The counters go to (0,1) and `frame_done` is not pulsed.

## Configuration
- `SOBEL_WIN_COORD_EN` defined:
  - Adds output ports `center_x` (ceil(log2 IMG_WIDTH) bits) and `center_y` (ceil(log2 IMG_HEIGHT) bits).
  - They carry the window centre (c-1, r-1), are registered with `start_calculations`, and reset to 0.
- Undefined: the ports and their registers are absent; all other behaviour is identical.

## Structure
- Shared package `sobel_pkg` holds:
  - `PIX_W` = 8.
  - `pixel_t` (logic [7:0]).
  - `window_t` (pixel_t [0:8]).
  - Window index constants `WIN_TL`=0 … `WIN_BR`=8.
  - Default `IMG_WIDTH`/`IMG_HEIGHT`.
- One sub-module, `sobel_line_buffer`:
  - Parameter IMG_WIDTH.
  - One write port and one asynchronous read port at the same address.
  - Read-old-data semantics.
  - Instantiated twice (line1, line2).

## Test plan
- 4x4 frame with pixel = 16r+c, continuous valid.
  - Strobes must be 4 in total.
  - First window: 0,1,2,16,17,18,32,33,34, one cycle after pixel (2,2).
  - Second window: 1,2,3,17,18,19,33,34,35.
  - `frame_done` must fire with the 4th strobe.
- Same frame with `pixel_valid` low for 3 cycles after pixel (2,2): `windowBuffer` holds 0..34 unchanged, `start_calculations` stays low, and the following window equals 1..35.
- Assert `reset` after pixel (3,1): all outputs go to 0 immediately. Replay the full frame and check the windows match the first test.
- `frame_start` re-asserted at mid-frame pixel (2,1): no strobe until new row 2, col 2. The first window then equals the new frame's rows 0–2.
- Back-to-back frames of 5x3 with no gap: 3 strobes per frame, and the `frame_done` count equals the frame count.
- With `SOBEL_WIN_COORD_EN`, using the 4x4 frame: `center_x`/`center_y` must be (1,1), (2,1), (1,2), (2,2) on successive strobes.
